// File: rtl/soml_pkg.sv
// Shared constants for the SOML hard-decision sweep: data widths, the 4-PAM
// level table and the sequencer state encoding.
package soml_pkg;

    localparam int SOML_N     = 32;
    localparam int SOML_Q     = 22;
    localparam int SOML_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // 4-PAM levels -3/-1/+1/+3 in Q22 fixed point, indexed 0..3.
    function automatic logic signed [SOML_N-1:0] level_val(input logic [1:0] idx);
        logic signed [SOML_N-1:0] v;
        case (idx)
            2'd0:    v = 32'hFF40_0000;
            2'd1:    v = 32'hFFC0_0000;
            2'd2:    v = 32'h0040_0000;
            default: v = 32'h00C0_0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/soml_min_lane.sv
// One lane of the sweep: latched sample, squared distance to the current level
// with saturation, running minimum and the committed result registers.
module soml_min_lane
    import soml_pkg::*;
#(
    parameter int N = SOML_N,
    parameter int Q = SOML_Q
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_step,
    input  logic         i_first,
    input  logic         i_commit,
    input  logic [1:0]   i_idx,
    input  logic [N-1:0] i_x,
    output logic [N-1:0] o_min_d,
    output logic [1:0]   o_min_idx
);

    logic signed [N-1:0]   r_x;
    logic [N-1:0]          r_run_d;
    logic [1:0]            r_run_idx;
    logic [N-1:0]          r_res_d;
    logic [1:0]            r_res_idx;

    logic signed [N-1:0]   w_level;
    logic signed [N:0]     w_diff;
    logic [2*N+1:0]        w_diff_x;
    logic signed [2*N+1:0] w_prod;
    logic signed [2*N+1:0] w_shift;
    logic [N-1:0]          w_d;
    logic                  w_take;
    logic [N-1:0]          w_min_d;
    logic [1:0]            w_min_idx;

    assign w_level  = level_val(i_idx);
    assign w_diff   = {r_x[N-1], r_x} - {w_level[N-1], w_level};
    assign w_diff_x = {{(N+1){w_diff[N]}}, w_diff};
    assign w_prod   = w_diff_x * w_diff_x;
    assign w_shift  = w_prod >>> Q;

    // The square is never negative, so any set bit at or above N-1 means overflow.
    assign w_d = (|w_shift[2*N+1:N-1]) ? {1'b0, {(N-1){1'b1}}} : {1'b0, w_shift[N-2:0]};

    // Strict less-than keeps the lowest index on ties.
    assign w_take    = i_first || (w_d < r_run_d);
    assign w_min_d   = w_take ? w_d   : r_run_d;
    assign w_min_idx = w_take ? i_idx : r_run_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x       <= '0;
            r_run_d   <= '0;
            r_run_idx <= '0;
            r_res_d   <= '0;
            r_res_idx <= '0;
        end else begin
            if (i_load) begin
                r_x <= i_x;
            end
            if (i_step) begin
                r_run_d   <= w_min_d;
                r_run_idx <= w_min_idx;
            end
            if (i_commit) begin
                r_res_d   <= w_min_d;
                r_res_idx <= w_min_idx;
            end
        end
    end

    assign o_min_d   = r_res_d;
    assign o_min_idx = r_res_idx;

endmodule

// File: rtl/soml_min_sweep_ctrl.sv
// SOML minimum-distance sweep sequencer: accepts a symbol, evaluates the four
// 4-PAM levels over four cycles and hands per-lane minima downstream.
module soml_min_sweep_ctrl
    import soml_pkg::*;
#(
    parameter int N     = SOML_N,
    parameter int Q     = SOML_Q,
    parameter int CNT_W = SOML_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     xI1,
    input  logic [N-1:0]     xQ1,
    input  logic [N-1:0]     xI2,
    input  logic [N-1:0]     xQ2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     min_dI1,
    output logic [N-1:0]     min_dQ1,
    output logic [N-1:0]     min_dI2,
    output logic [N-1:0]     min_dQ2,
    output logic [2:0]       min_idx_dI1,
    output logic [2:0]       min_idx_dQ1,
    output logic [2:0]       min_idx_dI2,
    output logic [2:0]       min_idx_dQ2,
    output logic [1:0]       sweep_idx,
    output logic             busy,
    output logic [CNT_W-1:0] sym_count
);

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_cnt;
    logic [CNT_W-1:0] r_sym_count;

    logic w_load;
    logic w_step;
    logic w_first;
    logic w_commit;
    logic w_retire;

    logic [N-1:0] w_x       [4];
    logic [N-1:0] w_min_d   [4];
    logic [1:0]   w_min_idx [4];

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_first      = 1'b0;
        w_commit     = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                w_step  = 1'b1;
                w_first = (r_cnt == 2'd0);
                if (r_cnt == 2'd3) begin
                    w_commit     = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Retiring and accepting in the same cycle sustains one symbol per five cycles.
                in_ready = out_ready;
                if (out_ready) begin
                    w_retire = 1'b1;
                    if (in_valid) begin
                        w_load       = 1'b1;
                        w_state_next = ST_SWEEP;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // r_cnt wraps 3->0 at the end of a sweep, so it is always 0 outside SWEEP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_sym_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + 2'd1;
            end
            if (w_retire) begin
                r_sym_count <= r_sym_count + 1'b1;
            end
        end
    end

    assign w_x[0] = xI1;
    assign w_x[1] = xQ1;
    assign w_x[2] = xI2;
    assign w_x[3] = xQ2;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            soml_min_lane #(
                .N (N),
                .Q (Q)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .i_load    (w_load),
                .i_step    (w_step),
                .i_first   (w_first),
                .i_commit  (w_commit),
                .i_idx     (r_cnt),
                .i_x       (w_x[gi]),
                .o_min_d   (w_min_d[gi]),
                .o_min_idx (w_min_idx[gi])
            );
        end
    endgenerate

    assign min_dI1     = w_min_d[0];
    assign min_dQ1     = w_min_d[1];
    assign min_dI2     = w_min_d[2];
    assign min_dQ2     = w_min_d[3];
    assign min_idx_dI1 = {1'b0, w_min_idx[0]};
    assign min_idx_dQ1 = {1'b0, w_min_idx[1]};
    assign min_idx_dI2 = {1'b0, w_min_idx[2]};
    assign min_idx_dQ2 = {1'b0, w_min_idx[3]};

    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_SWEEP);
    assign sweep_idx = r_cnt;
    assign sym_count = r_sym_count;

endmodule

// File: tb/tb_soml_min_sweep_ctrl.sv
// Self-checking bench for soml_min_sweep_ctrl: fixed vectors, random symbols
// against a distance model, backpressure, streaming and mid-sweep reset.
module tb_soml_min_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] xI1, xQ1, xI2, xQ2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] min_dI1, min_dQ1, min_dI2, min_dQ2;
    logic [2:0]  min_idx_dI1, min_idx_dQ1, min_idx_dI2, min_idx_dQ2;
    logic [1:0]  sweep_idx;
    logic        busy;
    logic [15:0] sym_count;

    int checks   = 0;
    int failures = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    soml_min_sweep_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .xI1         (xI1),
        .xQ1         (xQ1),
        .xI2         (xI2),
        .xQ2         (xQ2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .min_dI1     (min_dI1),
        .min_dQ1     (min_dQ1),
        .min_dI2     (min_dI2),
        .min_dQ2     (min_dQ2),
        .min_idx_dI1 (min_idx_dI1),
        .min_idx_dQ1 (min_idx_dQ1),
        .min_idx_dI2 (min_idx_dI2),
        .min_idx_dQ2 (min_idx_dQ2),
        .sweep_idx   (sweep_idx),
        .busy        (busy),
        .sym_count   (sym_count)
    );

    logic [3:0][31:0] o_d;
    logic [3:0][2:0]  o_i;
    assign o_d = {min_dQ2, min_dI2, min_dQ1, min_dI1};
    assign o_i = {min_idx_dQ2, min_idx_dI2, min_idx_dQ1, min_idx_dI1};

    typedef struct {
        logic [3:0][31:0] x;
        logic [3:0][31:0] d;
        logic [3:0][1:0]  idx;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: distance to level (2k-3)*2^22, floor-divided by 2^22, clipped to int32 max.
    function automatic logic [31:0] ref_d(input logic [31:0] x, input int k);
        longint lv, diff, q;
        lv   = longint'(2 * k - 3) * longint'(4194304);
        diff = longint'($signed(x)) - lv;
        q    = (diff * diff) / longint'(4194304);
        if (q > 64'sd2147483647) q = 64'sd2147483647;
        return 32'(q);
    endfunction

    task automatic ref_sym(input logic [3:0][31:0] x, output logic [3:0][31:0] d,
                           output logic [3:0][1:0] idx);
        for (int l = 0; l < 4; l++) begin
            logic [31:0] best;
            int bi;
            best = '0;
            bi   = 0;
            for (int k = 0; k < 4; k++) begin
                if (k == 0 || ref_d(x[l], k) < best) begin
                    best = ref_d(x[l], k);
                    bi   = k;
                end
            end
            d[l]   = best;
            idx[l] = 2'(bi);
        end
    endtask

    task automatic set_x(input logic [3:0][31:0] x);
        xI1 = x[0];
        xQ1 = x[1];
        xI2 = x[2];
        xQ2 = x[3];
    endtask

    task automatic check_result(input string tag, input logic [3:0][31:0] ed,
                                input logic [3:0][1:0] ei);
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("%s_min_d%0d", tag, l), o_d[l], ed[l]);
            chk($sformatf("%s_min_idx%0d", tag, l), o_i[l], {1'b0, ei[l]});
        end
    endtask

    // Counts negedges until out_valid; the result appears in the 5th cycle after acceptance.
    task automatic wait_result(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (lat < 4) begin
                chk({tag, "_sweep_idx"}, sweep_idx, 64'(lat));
                chk({tag, "_busy"}, busy, 1);
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 4);
    endtask

    task automatic run_sym(input string tag, input logic [3:0][31:0] x,
                           input logic [3:0][31:0] ed, input logic [3:0][1:0] ei);
        int n;
        @(negedge clk);
        set_x(x);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        set_x({$urandom, $urandom, $urandom, $urandom});
        wait_result(tag);
        chk({tag, "_out_valid"}, out_valid, 1);
        check_result(tag, ed, ei);
        chk({tag, "_count_hold"}, sym_count, 64'(exp_count));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_count = (exp_count + 1) % 65536;
        chk({tag, "_count"}, sym_count, 64'(exp_count));
        chk({tag, "_out_valid_fall"}, out_valid, 0);
    endtask

    initial begin
        logic [3:0][31:0] rx, rd;
        logic [3:0][1:0]  ri;
        logic [3:0][31:0] sx[8];
        logic [3:0][31:0] sd[8];
        logic [3:0][1:0]  si[8];
        int sent, got, last, seen;

        tbl[0].x = {4{32'h004C_CCCD}}; tbl[0].d = {4{32'h0002_8F5C}}; tbl[0].idx = {4{2'd2}};
        tbl[1].x = {4{32'h0000_0000}}; tbl[1].d = {4{32'h0040_0000}}; tbl[1].idx = {4{2'd1}};
        tbl[2].x = {4{32'hFEC0_0000}}; tbl[2].d = {4{32'h0100_0000}}; tbl[2].idx = {4{2'd0}};
        tbl[3].x = {4{32'h7FFF_FFFF}}; tbl[3].d = {4{32'h7FFF_FFFF}}; tbl[3].idx = {4{2'd0}};
        tbl[4].x   = {32'hFF80_0000, 32'h0080_0000, 32'hFFC0_0000, 32'h00C0_0000};
        tbl[4].d   = {32'h0040_0000, 32'h0040_0000, 32'h0000_0000, 32'h0000_0000};
        tbl[4].idx = {2'd0, 2'd2, 2'd1, 2'd3};
        tbl[5].x = {4{32'h8000_0000}}; tbl[5].d = {4{32'h7FFF_FFFF}}; tbl[5].idx = {4{2'd0}};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        set_x('0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sweep_idx", sweep_idx, 0);
        chk("rst_sym_count", sym_count, 0);
        check_result("rst", '0, '0);

        for (int i = 0; i < 6; i++) begin
            run_sym($sformatf("tbl%0d", i), tbl[i].x, tbl[i].d, tbl[i].idx);
        end

        for (int i = 0; i < 40; i++) begin
            for (int l = 0; l < 4; l++) begin
                rx[l] = ($urandom_range(0, 1) == 1) ? $urandom
                      : 32'($urandom_range(0, 25165824)) - 32'h00C0_0000;
            end
            ref_sym(rx, rd, ri);
            run_sym($sformatf("rnd%0d", i), rx, rd, ri);
        end

        // Backpressure: result held while a new symbol waits on in_valid.
        @(negedge clk);
        set_x(tbl[0].x);
        in_valid = 1'b1;
        @(negedge clk);
        set_x(tbl[1].x);
        wait_result("bp_a");
        for (int c = 0; c < 10; c++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            check_result("bp_hold", tbl[0].d, tbl[0].idx);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        exp_count = (exp_count + 1) % 65536;
        chk("bp_retire_count", sym_count, 64'(exp_count));
        chk("bp_out_valid_low", out_valid, 0);
        wait_result("bp_b");
        check_result("bp_b", tbl[1].d, tbl[1].idx);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_count = (exp_count + 1) % 65536;

        // Back-to-back stream with downstream always ready.
        for (int i = 0; i < 8; i++) begin
            sx[i] = {$urandom, $urandom, $urandom, 32'($urandom_range(0, 25165824)) - 32'h00C0_0000};
            ref_sym(sx[i], sd[i], si[i]);
        end
        out_ready = 1'b1;
        sent = 0;
        got  = 0;
        last = 0;
        for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                check_result($sformatf("stream%0d", got), sd[got], si[got]);
                if (got > 0) chk("stream_gap", 64'(cyc - last), 5);
                last = cyc;
                got++;
            end
            if (sent < 8) begin
                set_x(sx[sent]);
                in_valid = 1'b1;
                if (in_ready) sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        exp_count = (exp_count + 8) % 65536;
        chk("stream_results", got, 8);
        chk("stream_count", sym_count, 64'(exp_count));

        // Reset two steps into a sweep abandons the symbol.
        @(negedge clk);
        set_x(tbl[0].x);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_sweep_idx", sweep_idx, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_sym_count", sym_count, 0);
        check_result("abort", '0, '0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen += int'(out_valid);
        end
        chk("abort_no_result", seen, 0);
        run_sym("after_abort", tbl[4].x, tbl[4].d, tbl[4].idx);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
